// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage register with a 2-entry skid.
// Optional stall/flush statistics enabled by PIPE_STAGE_BUF_STATS_EN.
module pipe_stage_buf #(
  parameter int unsigned            PAYLOAD_W = 104,
  parameter logic [PAYLOAD_W-1:0]   RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy
`ifdef PIPE_STAGE_BUF_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_drop_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 accept;
  logic                 pop;

  // Ready comes from registered state only, held low while in reset.
  assign in_ready    = rst_n & (state != FULL);
  assign out_valid   = (state != EMPTY);
  assign out_payload = main_q;
  assign occupancy   = state;
  assign accept      = in_valid & in_ready;
  assign pop         = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            main_q <= in_payload;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept && !pop: begin
              state  <= FULL;
              skid_q <= in_payload;
            end
            accept && pop: begin
              main_q <= in_payload;
            end
            !accept && pop: begin
              state <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [32:0] drop_sum;

  assign drop_sum = {1'b0, flush_drop_cnt} + {31'd0, occupancy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt      <= '0;
      flush_drop_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush)
        flush_drop_cnt <= drop_sum[32] ? 32'hFFFF_FFFF
                                       : drop_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of pipe_stage_buf handshake,
// skid ordering, flush and async reset (plus stats when enabled).
module tb_pipe_stage_buf;

  localparam int W = 104;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_payload;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_payload;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_drop_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.PAYLOAD_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .occupancy   (occupancy)
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_drop_cnt (flush_drop_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_payload = 104'hA5;
    flush      = 1'b0;
    out_ready  = 1'b0;

    // 1. reset
    #12;
    chk("rst_in_ready", W'(in_ready), 0);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_payload", out_payload, 0);
    chk("rst_occ", W'(occupancy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", W'(in_ready), 1);
    step();
    chk("first_valid", W'(out_valid), 1);
    chk("first_payload", out_payload, 104'hA5);
    chk("first_occ", W'(occupancy), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("drain_occ", W'(occupancy), 0);

`ifdef PIPE_STAGE_BUF_STATS_EN
    chk("stats_init_stall", W'(stall_cnt), 0);
    chk("stats_init_drop", W'(flush_drop_cnt), 0);
`endif

    // 2. streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid   = 1'b1;
      in_payload = W'(i);
      #1;
      chk("strm_in_ready", W'(in_ready), 1);
      step();
      chk("strm_payload", out_payload, W'(i));
      chk("strm_occ", W'(occupancy), 1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_end_occ", W'(occupancy), 0);

    // 3. backpressure
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 104'd1;
    step();
    chk("bp_occ1", W'(occupancy), 1);
    chk("bp_rdy1", W'(in_ready), 1);
    in_payload = 104'd2;
    step();
    chk("bp_occ2", W'(occupancy), 2);
    chk("bp_rdy2", W'(in_ready), 0);
    chk("bp_out1", out_payload, 104'd1);
    in_payload = 104'd3;
    step();
    chk("bp_hold_occ", W'(occupancy), 2);
    chk("bp_hold_out", out_payload, 104'd1);
    out_ready = 1'b1;
    step();
    chk("bp_out2", out_payload, 104'd2);
    chk("bp_occ_after", W'(occupancy), 1);
    chk("bp_rdy_after", W'(in_ready), 1);
    step();
    chk("bp_out3", out_payload, 104'd3);
    chk("bp_occ_3", W'(occupancy), 1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", W'(out_valid), 0);

    // 4. flush in FULL with concurrent in_valid
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 104'h11;
    step();
    in_payload = 104'h22;
    step();
    chk("fl_occ2", W'(occupancy), 2);
    flush      = 1'b1;
    in_payload = 104'h9;
    step();
    chk("fl_occ0", W'(occupancy), 0);
    chk("fl_valid0", W'(out_valid), 0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fl_stay_empty", W'(out_valid), 0);
    // flush while ONE with an accepted beat
    in_valid   = 1'b1;
    in_payload = 104'h77;
    step();
    chk("fl1_occ", W'(occupancy), 1);
    flush      = 1'b1;
    in_payload = 104'h88;
    step();
    chk("fl1_occ0", W'(occupancy), 0);
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl1_no_out", W'(out_valid), 0);

    // 5. async reset mid-transfer
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 104'h33;
    step();
    in_payload = 104'h44;
    step();
    in_valid = 1'b0;
    chk("ar_occ2", W'(occupancy), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", W'(out_valid), 0);
    chk("ar_occ", W'(occupancy), 0);
    chk("ar_rdy", W'(in_ready), 0);
    chk("ar_payload", out_payload, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_post_valid", W'(out_valid), 0);

`ifdef PIPE_STAGE_BUF_STATS_EN
    // 6. statistics
    chk("st_rst_stall", W'(stall_cnt), 0);
    in_valid   = 1'b1;
    in_payload = 104'h55;
    step();
    in_valid = 1'b0;
    chk("st_after_load", W'(stall_cnt), 0);
    for (int i = 0; i < 5; i++) step();
    chk("st_stall5", W'(stall_cnt), 5);
    in_valid   = 1'b1;
    in_payload = 104'h66;
    step();
    in_valid = 1'b0;
    chk("st_occ2", W'(occupancy), 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("st_drop2", W'(flush_drop_cnt), 2);
    chk("st_stall7", W'(stall_cnt), 7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
